tcp_tx_seg_sched: RTL and testbench

TCP_TX_SEG_SCHED -- requirements
Module: tcp_tx_seg_sched

---
 rtl/tcp_sched_pkg.sv | 30 +++
 rtl/tcp_sched_prio.sv | 33 +++
 rtl/tcp_tx_seg_sched.sv | 233 +++++++++++++++++++++++
 tb/tb_tcp_tx_seg_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_sched_pkg.sv
// Shared types and constants for the TCP TX segment scheduler.
//   state_e : scheduler FSM states
//   src_e   : segment source identifiers (also the grant_src encoding)
//   FLG_*   : bit positions inside the 5-bit TCP flag vector
//   FLAGS_* : fixed flag patterns used for disconnect-ACK and data segments
package tcp_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_CTL  = 2'd1,
        SRC_DCN  = 2'd2,
        SRC_DAT  = 2'd3
    } src_e;

    localparam int FLG_ACK = 0;
    localparam int FLG_FIN = 1;
    localparam int FLG_SYN = 2;
    localparam int FLG_RST = 3;
    localparam int FLG_PSH = 4;

    localparam logic [4:0] FLAGS_DCN = 5'(1 << FLG_ACK);
    localparam logic [4:0] FLAGS_DAT = 5'((1 << FLG_ACK) | (1 << FLG_PSH));

endpackage

// File: rtl/tcp_sched_prio.sv
// Combinational priority decode for the segment scheduler.
// Inputs : ctl_req, dcn_req, dat_req - pending requests
//          ctl_rst - RST flag of the pending control segment
//          starve  - data source has lost STARVE_MAX arbitrations in a row
// Output : winner  - source that wins this cycle, SRC_NONE if no request
module tcp_sched_prio
    import tcp_sched_pkg::*;
(
    input  logic ctl_req,
    input  logic dcn_req,
    input  logic dat_req,
    input  logic ctl_rst,
    input  logic starve,
    output src_e winner
);

    // A connection reset must never wait behind data, even a starved source.
    always_comb begin
        winner = SRC_NONE;
        if (ctl_req && ctl_rst) begin
            winner = SRC_CTL;
        end else if (dat_req && starve) begin
            winner = SRC_DAT;
        end else if (ctl_req) begin
            winner = SRC_CTL;
        end else if (dcn_req) begin
            winner = SRC_DCN;
        end else if (dat_req) begin
            winner = SRC_DAT;
        end
    end

endmodule

// File: rtl/tcp_tx_seg_sched.sv
// TCP TX segment scheduler: arbitrates between the server control FSM,
// the disconnect-ACK generator and the data engine, latches the winning
// segment header, hands it to the TX engine and waits for completion
// under a watchdog.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   ctl_* / dcn_* / dat_*            - per-source request and header fields
//   local_port, remote_port          - connection ports, sampled at grant
//   abort_in                         - abandon the current segment
//   ctl_gnt, dcn_gnt, dat_gnt        - one-cycle grant pulses
//   hdr_vld/hdr_rdy, hdr_*           - header handshake to the TX engine
//   tx_done_in                       - TX engine finished the segment
//   busy, timeout, grant_src         - status
//
// state | meaning
// IDLE  | arbitrate pending requests every cycle
// SEND  | header presented, waiting for hdr_rdy
// WAIT  | header accepted, waiting for tx_done_in or watchdog expiry
module tcp_tx_seg_sched
    import tcp_sched_pkg::*;
#(
    parameter int TX_TIMEOUT = 1000,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctl_req,
    input  logic [4:0]  ctl_flags,
    input  logic [31:0] ctl_seq,
    input  logic [31:0] ctl_ack,
    input  logic        dcn_req,
    input  logic [31:0] dcn_seq,
    input  logic [31:0] dcn_ack,
    input  logic        dat_req,
    input  logic [31:0] dat_seq,
    input  logic [31:0] dat_ack,
    input  logic [15:0] dat_len,
    input  logic [15:0] local_port,
    input  logic [15:0] remote_port,
    input  logic        abort_in,
    output logic        ctl_gnt,
    output logic        dcn_gnt,
    output logic        dat_gnt,
    output logic        hdr_vld,
    input  logic        hdr_rdy,
    output logic [4:0]  hdr_flags,
    output logic [31:0] hdr_seq,
    output logic [31:0] hdr_ack,
    output logic [15:0] hdr_src_port,
    output logic [15:0] hdr_dst_port,
    output logic [15:0] hdr_len,
    input  logic        tx_done_in,
    output logic        busy,
    output logic        timeout,
    output logic [1:0]  grant_src
);

    localparam int                SKIP_W    = (STARVE_MAX < 4) ? 2 : $clog2(STARVE_MAX + 1);
    localparam logic [SKIP_W-1:0] SKIP_MAX  = SKIP_W'(STARVE_MAX);
    localparam logic [15:0]       WDOG_LAST = 16'(TX_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [15:0]       wdog_q, wdog_d;
    logic              ctl_gnt_q, ctl_gnt_d;
    logic              dcn_gnt_q, dcn_gnt_d;
    logic              dat_gnt_q, dat_gnt_d;
    logic              hdr_vld_q, hdr_vld_d;
    logic [4:0]        hdr_flags_q, hdr_flags_d;
    logic [31:0]       hdr_seq_q, hdr_seq_d;
    logic [31:0]       hdr_ack_q, hdr_ack_d;
    logic [15:0]       hdr_src_port_q, hdr_src_port_d;
    logic [15:0]       hdr_dst_port_q, hdr_dst_port_d;
    logic [15:0]       hdr_len_q, hdr_len_d;
    logic              timeout_q, timeout_d;
    src_e              grant_src_q, grant_src_d;
    src_e              winner;

    tcp_sched_prio u_prio (
        .ctl_req (ctl_req),
        .dcn_req (dcn_req),
        .dat_req (dat_req),
        .ctl_rst (ctl_flags[FLG_RST]),
        .starve  (skip_q == SKIP_MAX),
        .winner  (winner)
    );

    always_comb begin
        state_d        = state_q;
        skip_d         = skip_q;
        wdog_d         = wdog_q;
        ctl_gnt_d      = 1'b0;
        dcn_gnt_d      = 1'b0;
        dat_gnt_d      = 1'b0;
        hdr_vld_d      = hdr_vld_q;
        hdr_flags_d    = hdr_flags_q;
        hdr_seq_d      = hdr_seq_q;
        hdr_ack_d      = hdr_ack_q;
        hdr_src_port_d = hdr_src_port_q;
        hdr_dst_port_d = hdr_dst_port_q;
        hdr_len_d      = hdr_len_q;
        timeout_d      = 1'b0;
        grant_src_d    = grant_src_q;

        if (abort_in) begin
            // Starvation history survives an abort so the data source keeps its credit.
            state_d     = ST_IDLE;
            hdr_vld_d   = 1'b0;
            wdog_d      = '0;
            grant_src_d = SRC_NONE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    hdr_vld_d   = 1'b0;
                    grant_src_d = SRC_NONE;
                    if (winner != SRC_NONE) begin
                        state_d        = ST_SEND;
                        hdr_vld_d      = 1'b1;
                        grant_src_d    = winner;
                        hdr_src_port_d = local_port;
                        hdr_dst_port_d = remote_port;
                        unique case (winner)
                            SRC_CTL: begin
                                ctl_gnt_d   = 1'b1;
                                hdr_flags_d = ctl_flags;
                                hdr_seq_d   = ctl_seq;
                                hdr_ack_d   = ctl_ack;
                                hdr_len_d   = '0;
                            end
                            SRC_DCN: begin
                                dcn_gnt_d   = 1'b1;
                                hdr_flags_d = FLAGS_DCN;
                                hdr_seq_d   = dcn_seq;
                                hdr_ack_d   = dcn_ack;
                                hdr_len_d   = '0;
                            end
                            default: begin
                                dat_gnt_d   = 1'b1;
                                hdr_flags_d = FLAGS_DAT;
                                hdr_seq_d   = dat_seq;
                                hdr_ack_d   = dat_ack;
                                hdr_len_d   = dat_len;
                            end
                        endcase
                        if (winner == SRC_DAT) begin
                            skip_d = '0;
                        end else if (dat_req && (skip_q != SKIP_MAX)) begin
                            skip_d = skip_q + 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    wdog_d = '0;
                    if (hdr_rdy) begin
                        state_d   = ST_WAIT;
                        hdr_vld_d = 1'b0;
                    end
                end
                ST_WAIT: begin
                    // Completion beats expiry when both land in the same cycle.
                    if (tx_done_in) begin
                        state_d     = ST_IDLE;
                        wdog_d      = '0;
                        grant_src_d = SRC_NONE;
                    end else if (wdog_q == WDOG_LAST) begin
                        state_d     = ST_IDLE;
                        wdog_d      = '0;
                        timeout_d   = 1'b1;
                        grant_src_d = SRC_NONE;
                    end else begin
                        wdog_d = wdog_q + 16'd1;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    hdr_vld_d   = 1'b0;
                    grant_src_d = SRC_NONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            skip_q         <= '0;
            wdog_q         <= '0;
            ctl_gnt_q      <= 1'b0;
            dcn_gnt_q      <= 1'b0;
            dat_gnt_q      <= 1'b0;
            hdr_vld_q      <= 1'b0;
            hdr_flags_q    <= '0;
            hdr_seq_q      <= '0;
            hdr_ack_q      <= '0;
            hdr_src_port_q <= '0;
            hdr_dst_port_q <= '0;
            hdr_len_q      <= '0;
            timeout_q      <= 1'b0;
            grant_src_q    <= SRC_NONE;
        end else begin
            state_q        <= state_d;
            skip_q         <= skip_d;
            wdog_q         <= wdog_d;
            ctl_gnt_q      <= ctl_gnt_d;
            dcn_gnt_q      <= dcn_gnt_d;
            dat_gnt_q      <= dat_gnt_d;
            hdr_vld_q      <= hdr_vld_d;
            hdr_flags_q    <= hdr_flags_d;
            hdr_seq_q      <= hdr_seq_d;
            hdr_ack_q      <= hdr_ack_d;
            hdr_src_port_q <= hdr_src_port_d;
            hdr_dst_port_q <= hdr_dst_port_d;
            hdr_len_q      <= hdr_len_d;
            timeout_q      <= timeout_d;
            grant_src_q    <= grant_src_d;
        end
    end

    assign ctl_gnt      = ctl_gnt_q;
    assign dcn_gnt      = dcn_gnt_q;
    assign dat_gnt      = dat_gnt_q;
    assign hdr_vld      = hdr_vld_q;
    assign hdr_flags    = hdr_flags_q;
    assign hdr_seq      = hdr_seq_q;
    assign hdr_ack      = hdr_ack_q;
    assign hdr_src_port = hdr_src_port_q;
    assign hdr_dst_port = hdr_dst_port_q;
    assign hdr_len      = hdr_len_q;
    assign timeout      = timeout_q;
    assign grant_src    = grant_src_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tcp_tx_seg_sched.sv
module tb_tcp_tx_seg_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctl_req, dcn_req, dat_req;
    logic [4:0]  ctl_flags;
    logic [31:0] ctl_seq, ctl_ack, dcn_seq, dcn_ack, dat_seq, dat_ack;
    logic [15:0] dat_len, local_port, remote_port;
    logic        abort_in, hdr_rdy, tx_done_in;
    logic        ctl_gnt, dcn_gnt, dat_gnt, hdr_vld, busy, timeout;
    logic [4:0]  hdr_flags;
    logic [31:0] hdr_seq, hdr_ack;
    logic [15:0] hdr_src_port, hdr_dst_port, hdr_len;
    logic [1:0]  grant_src;

    int n_checks = 0;
    int n_fail   = 0;

    tcp_tx_seg_sched #(.TX_TIMEOUT(8), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .ctl_req(ctl_req), .ctl_flags(ctl_flags), .ctl_seq(ctl_seq), .ctl_ack(ctl_ack),
        .dcn_req(dcn_req), .dcn_seq(dcn_seq), .dcn_ack(dcn_ack),
        .dat_req(dat_req), .dat_seq(dat_seq), .dat_ack(dat_ack), .dat_len(dat_len),
        .local_port(local_port), .remote_port(remote_port), .abort_in(abort_in),
        .ctl_gnt(ctl_gnt), .dcn_gnt(dcn_gnt), .dat_gnt(dat_gnt),
        .hdr_vld(hdr_vld), .hdr_rdy(hdr_rdy), .hdr_flags(hdr_flags),
        .hdr_seq(hdr_seq), .hdr_ack(hdr_ack), .hdr_src_port(hdr_src_port),
        .hdr_dst_port(hdr_dst_port), .hdr_len(hdr_len), .tx_done_in(tx_done_in),
        .busy(busy), .timeout(timeout), .grant_src(grant_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ctl, dcn, dat;
        logic [4:0]  cflags;
        logic [15:0] lport, rport, dlen;
        logic [1:0]  exp_src;
        logic [4:0]  exp_flags;
        logic [31:0] exp_seq, exp_ack;
        logic [15:0] exp_len;
    } vec_t;

    localparam logic [31:0] CS = 32'h0000_07D0, CA = 32'h0000_0101;
    localparam logic [31:0] NS = 32'h0000_1111, NA = 32'h0000_2222;
    localparam logic [31:0] TS = 32'h0000_3333, TA = 32'h0000_4444;

    vec_t vecs[9];

    function automatic vec_t mk(logic c, logic n, logic d, logic [4:0] cf,
                                logic [15:0] lp, logic [15:0] rp, logic [15:0] dl,
                                logic [1:0] es, logic [4:0] ef, logic [31:0] eq,
                                logic [31:0] ea, logic [15:0] el);
        vec_t v;
        v.ctl = c; v.dcn = n; v.dat = d; v.cflags = cf;
        v.lport = lp; v.rport = rp; v.dlen = dl;
        v.exp_src = es; v.exp_flags = ef; v.exp_seq = eq; v.exp_ack = ea; v.exp_len = el;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        ctl_req = 1'b0; dcn_req = 1'b0; dat_req = 1'b0;
    endtask

    // Drive requests, grant, accept header at once, complete immediately.
    task automatic run_vec(input int i, input vec_t v);
        string p;
        logic [2:0] exp_gnt;
        p = $sformatf("vec%0d", i);
        exp_gnt = (v.exp_src == 2'd1) ? 3'b100 : (v.exp_src == 2'd2) ? 3'b010 : 3'b001;
        ctl_req = v.ctl; dcn_req = v.dcn; dat_req = v.dat; ctl_flags = v.cflags;
        local_port = v.lport; remote_port = v.rport; dat_len = v.dlen;
        hdr_rdy = 1'b0;
        tick();
        clear_reqs();
        check({p, "_gnt"},   {29'd0, ctl_gnt, dcn_gnt, dat_gnt}, {29'd0, exp_gnt});
        check({p, "_vld"},   {31'd0, hdr_vld}, 32'd1);
        check({p, "_src"},   {30'd0, grant_src}, {30'd0, v.exp_src});
        check({p, "_flags"}, {27'd0, hdr_flags}, {27'd0, v.exp_flags});
        check({p, "_seq"},   hdr_seq, v.exp_seq);
        check({p, "_ack"},   hdr_ack, v.exp_ack);
        check({p, "_len"},   {16'd0, hdr_len}, {16'd0, v.exp_len});
        check({p, "_ports"}, {hdr_src_port, hdr_dst_port}, {v.lport, v.rport});
        hdr_rdy = 1'b1;
        tick();
        hdr_rdy = 1'b0;
        check({p, "_wait"},  {28'd0, busy, hdr_vld, ctl_gnt | dcn_gnt | dat_gnt, 1'b0}, 32'h8);
        tx_done_in = 1'b1;
        tick();
        tx_done_in = 1'b0;
        check({p, "_idle"},  {29'd0, busy, grant_src}, 32'd0);
    endtask

    // Returns after the tick that lands in the first WAIT cycle.
    task automatic go_to_wait();
        ctl_req = 1'b1; ctl_flags = 5'h01; hdr_rdy = 1'b1;
        tick();
        ctl_req = 1'b0;
        tick();
        hdr_rdy = 1'b0;
    endtask

    initial begin
        int first_k, pulses;
        logic [4:0]  s_flags;
        logic [31:0] s_seq;

        rst = 1'b1; clear_reqs(); ctl_flags = 5'h0;
        ctl_seq = CS; ctl_ack = CA; dcn_seq = NS; dcn_ack = NA; dat_seq = TS; dat_ack = TA;
        dat_len = 16'd0; local_port = 16'd0; remote_port = 16'd0;
        abort_in = 1'b0; hdr_rdy = 1'b0; tx_done_in = 1'b0;
        tick(); tick();
        check("reset_ctrl", {24'd0, ctl_gnt, dcn_gnt, dat_gnt, hdr_vld, busy, timeout, grant_src}, 32'd0);
        check("reset_hdr",  {hdr_flags, hdr_len, 11'd0} | hdr_seq | hdr_ack | {hdr_src_port, hdr_dst_port}, 32'd0);
        rst = 1'b0;
        tick();

        vecs[0] = mk(1,0,0, 5'h05, 16'd80, 16'd5000, 16'd0,   2'd1, 5'h05, CS, CA, 16'd0);
        vecs[1] = mk(0,1,0, 5'h01, 16'd81, 16'd5001, 16'd0,   2'd2, 5'h01, NS, NA, 16'd0);
        vecs[2] = mk(0,0,1, 5'h01, 16'd82, 16'd5002, 16'd512, 2'd3, 5'h11, TS, TA, 16'd512);
        vecs[3] = mk(1,1,1, 5'h01, 16'd83, 16'd5003, 16'd100, 2'd1, 5'h01, CS, CA, 16'd0);
        vecs[4] = mk(0,1,1, 5'h01, 16'd84, 16'd5004, 16'd100, 2'd2, 5'h01, NS, NA, 16'd0);
        vecs[5] = mk(1,0,1, 5'h01, 16'd85, 16'd5005, 16'd100, 2'd1, 5'h01, CS, CA, 16'd0);
        vecs[6] = mk(1,0,1, 5'h08, 16'd86, 16'd5006, 16'd100, 2'd1, 5'h08, CS, CA, 16'd0);
        vecs[7] = mk(1,1,1, 5'h01, 16'd87, 16'd5007, 16'd200, 2'd3, 5'h11, TS, TA, 16'd200);
        vecs[8] = mk(1,1,0, 5'h03, 16'd88, 16'd5008, 16'd0,   2'd1, 5'h03, CS, CA, 16'd0);
        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Starvation with both requests held continuously.
        ctl_req = 1'b1; ctl_flags = 5'h01; dat_req = 1'b1; dat_len = 16'd512;
        local_port = 16'd80; remote_port = 16'd5000;
        for (int t = 0; t < 4; t++) begin
            tick();
            check($sformatf("starve%0d_src", t), {30'd0, grant_src}, (t < 3) ? 32'd1 : 32'd3);
            if (t == 3) begin
                check("starve_dat_gnt", {31'd0, dat_gnt}, 32'd1);
                check("starve_flags", {27'd0, hdr_flags}, 32'h11);
                check("starve_len", {16'd0, hdr_len}, 32'd512);
            end
            hdr_rdy = 1'b1; tick(); hdr_rdy = 1'b0;
            tx_done_in = 1'b1; tick(); tx_done_in = 1'b0;
        end
        clear_reqs();

        // Ten-cycle header stall; tx_done_in must not end SEND.
        ctl_req = 1'b1; ctl_flags = 5'h05; local_port = 16'd443; remote_port = 16'd6000;
        tick();
        ctl_req = 1'b0;
        s_flags = hdr_flags; s_seq = hdr_seq;
        check("stall_first", {30'd0, ctl_gnt, hdr_vld}, 32'd3);
        tx_done_in = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("stall%0d", c),
                  {ctl_gnt, busy, hdr_vld, hdr_flags, hdr_src_port, 8'd0} ^ s_seq,
                  {1'b0, 1'b1, 1'b1, 5'h05, 16'd443, 8'd0} ^ CS);
            if (c == 9) hdr_rdy = 1'b1;
        end
        tx_done_in = 1'b0;
        check("stall_still_send", {30'd0, busy, hdr_vld}, 32'd3);
        tick();
        hdr_rdy = 1'b0;
        check("stall_wait", {30'd0, busy, hdr_vld}, 32'd2);
        check("stall_flags_kept", {27'd0, hdr_flags}, {27'd0, s_flags});
        tx_done_in = 1'b1; tick(); tx_done_in = 1'b0;

        // Watchdog expiry, bounded observation window.
        go_to_wait();
        first_k = -1; pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (timeout) begin
                pulses++;
                if (first_k < 0) first_k = k;
            end
        end
        check("tmo_delay", first_k, 32'd8);
        check("tmo_pulses", pulses, 32'd1);
        check("tmo_idle", {30'd0, busy, hdr_vld} | {30'd0, grant_src}, 32'd0);

        // Completion in the same cycle as expiry wins.
        go_to_wait();
        pulses = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (timeout) pulses++;
        end
        tx_done_in = 1'b1;
        tick();
        tx_done_in = 1'b0;
        if (timeout) pulses++;
        check("done_beats_tmo", pulses, 32'd0);
        check("done_idle", {31'd0, busy}, 32'd0);
        tick();
        check("done_no_late_tmo", {31'd0, timeout}, 32'd0);

        // Abort in SEND, then abort against a fresh request in IDLE.
        ctl_req = 1'b1; ctl_flags = 5'h01;
        tick();
        ctl_req = 1'b0;
        check("abort_pre", {30'd0, busy, hdr_vld}, 32'd3);
        abort_in = 1'b1;
        tick();
        check("abort_send", {27'd0, busy, hdr_vld, ctl_gnt, grant_src}, 32'd0);
        ctl_req = 1'b1;
        tick();
        check("abort_idle", {28'd0, busy, ctl_gnt, dcn_gnt, dat_gnt}, 32'd0);
        abort_in = 1'b0; ctl_req = 1'b0;
        tick();

        // Reset while waiting on the TX engine.
        dat_req = 1'b1; dat_len = 16'd64; hdr_rdy = 1'b1;
        tick();
        dat_req = 1'b0;
        tick();
        hdr_rdy = 1'b0;
        check("rst_pre_wait", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (timeout) pulses++;
        end
        check("rst_ctrl", {24'd0, ctl_gnt, dcn_gnt, dat_gnt, hdr_vld, busy, timeout, grant_src}, 32'd0);
        check("rst_hdr", {hdr_flags, hdr_len, 11'd0} | hdr_seq | hdr_ack | {hdr_src_port, hdr_dst_port}, 32'd0);
        check("rst_no_tmo", pulses, 32'd0);
        rst = 1'b0;
        tick();
        check("rst_after", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
